sha3_axis_padder: RTL

- AXI-Stream front end for the SHA-3 core.
- Accepts message bytes on a WIDTH-bit slave stream, packs them into rate-sized blocks and applies FIPS-202 SHA-3 padding (0x06 … 0x80) in hardware. The mode is selectable per message.
- Presents complete blocks on a valid/ready block interface to the Keccak permutation wrapper.
- Replaces padding precomputed by software or the bench: messages of arbitrary byte length are accepted directly.

---
 rtl/sha3_pkg.sv | 29 ++
 rtl/sha3_beat_merge.sv | 33 +++
 rtl/sha3_axis_padder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// Shared SHA-3 types and constants: hash modes, rates, padding bytes and padder FSM states.
package sha3_pkg;

  typedef enum logic [1:0] {
    SHA3_224 = 2'd0,
    SHA3_256 = 2'd1,
    SHA3_384 = 2'd2,
    SHA3_512 = 2'd3
  } sha3_mode_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    EMIT   = 2'd1,
    PADBLK = 2'd2
  } pad_state_t;

  localparam logic [7:0] PAD_DS  = 8'h06;
  localparam logic [7:0] PAD_END = 8'h80;

  function automatic logic [7:0] rate_bytes(input sha3_mode_t mode);
    case (mode)
      SHA3_224: rate_bytes = 8'd144;
      SHA3_256: rate_bytes = 8'd136;
      SHA3_384: rate_bytes = 8'd104;
      default:  rate_bytes = 8'd72;
    endcase
  endfunction

endpackage

// File: rtl/sha3_beat_merge.sv
// Writes the first 'count' lanes of a stream beat into a block buffer at a byte offset,
// optionally following them with the SHA-3 domain byte.
module sha3_beat_merge
  import sha3_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_RATE = 1152
) (
  input  logic [MAX_RATE-1:0] buf_in,
  input  logic [WIDTH-1:0]    data,
  input  logic [7:0]          ptr,
  input  logic [7:0]          count,
  input  logic [7:0]          limit,
  input  logic                pad_en,
  output logic [MAX_RATE-1:0] buf_out
);

  localparam int Lanes = int'(WIDTH / 8);

  always_comb begin
    buf_out = buf_in;
    // Bytes at or past the rate limit are never touched, so the unused block tail stays zero.
    for (int i = 0; i < Lanes; i++) begin
      if (i < int'(count) && int'(ptr) + i < int'(limit)) begin
        buf_out[8*(int'(ptr)+i) +: 8] = data[8*i +: 8];
      end
    end
    if (pad_en && int'(ptr) + int'(count) < int'(limit)) begin
      buf_out[8*(int'(ptr)+int'(count)) +: 8] = PAD_DS;
    end
  end

endmodule

// File: rtl/sha3_axis_padder.sv
// AXI-Stream to SHA-3 block packer: packs message bytes into rate-sized blocks and applies
// the 0x06..0x80 padding, handing complete blocks to the permutation over valid/ready.
module sha3_axis_padder
  import sha3_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_RATE = 1152
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic [WIDTH-1:0]     s_tdata,
  input  logic [WIDTH/8-1:0]   s_tkeep,
  input  logic                 s_tlast,
  input  logic [1:0]           s_tuser,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [MAX_RATE-1:0]  m_block,
  output logic [1:0]           m_mode,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 err
);

  localparam int unsigned Lanes = WIDTH / 8;

  pad_state_t          state;
  logic [7:0]          ptr;
  logic                msg_active;
  logic                pad_pending;

  sha3_mode_t          eff_mode;
  logic [7:0]          rate;
  logic [7:0]          cur_rate;
  logic [7:0]          cnt;
  logic [8:0]          p_new;
  logic                full;
  logic                keep_bad;
  logic                accept;
  logic [MAX_RATE-1:0] merged;
  logic [MAX_RATE-1:0] end_mask;
  logic [MAX_RATE-1:0] pad_blk;

  always_comb begin
    // The first beat of a message uses the incoming mode; later beats use the latched one.
    eff_mode = msg_active ? sha3_mode_t'(m_mode) : sha3_mode_t'(s_tuser);
    rate     = rate_bytes(eff_mode);
    cur_rate = rate_bytes(sha3_mode_t'(m_mode));
    cnt      = '0;
    for (int i = 0; i < int'(Lanes); i++) begin
      cnt = cnt + 8'(s_tkeep[i]);
    end
    p_new    = {1'b0, ptr} + {1'b0, cnt};
    full     = (p_new >= {1'b0, rate});
    keep_bad = ((s_tkeep & (s_tkeep + Lanes'(1))) != '0) || (!s_tlast && (s_tkeep != '1));
    accept   = s_tvalid && s_tready && (state == FILL);
    end_mask = '0;
    end_mask[8*(int'(rate)-1) +: 8] = PAD_END;
    pad_blk  = '0;
    pad_blk[7:0] = PAD_DS;
    pad_blk[8*(int'(cur_rate)-1) +: 8] = PAD_END;
  end

  sha3_beat_merge #(
    .WIDTH    (WIDTH),
    .MAX_RATE (MAX_RATE)
  ) u_merge (
    .buf_in  (m_block),
    .data    (s_tdata),
    .ptr     (ptr),
    .count   (cnt),
    .limit   (rate),
    .pad_en  (s_tlast && !full),
    .buf_out (merged)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state       <= FILL;
      ptr         <= '0;
      msg_active  <= 1'b0;
      pad_pending <= 1'b0;
      s_tready    <= 1'b0;
      m_block     <= '0;
      m_mode      <= '0;
      m_last      <= 1'b0;
      m_valid     <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          s_tready <= 1'b1;
          if (accept) begin
            if (keep_bad) err <= 1'b1;
            if (!msg_active) m_mode <= s_tuser;
            if (!s_tlast && !full) begin
              m_block    <= merged;
              ptr        <= p_new[7:0];
              msg_active <= 1'b1;
            end else begin
              s_tready <= 1'b0;
              m_valid  <= 1'b1;
              ptr      <= '0;
              state    <= EMIT;
              if (s_tlast && !full) begin
                m_block    <= merged | end_mask;
                m_last     <= 1'b1;
                msg_active <= 1'b0;
              end else begin
                // A message ending exactly on the rate still owes a whole padding block.
                m_block     <= merged;
                m_last      <= 1'b0;
                msg_active  <= !s_tlast;
                pad_pending <= s_tlast;
              end
            end
          end
        end
        EMIT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_block <= '0;
            if (pad_pending) begin
              state <= PADBLK;
            end else begin
              state    <= FILL;
              s_tready <= 1'b1;
            end
          end
        end
        PADBLK: begin
          m_block     <= pad_blk;
          m_last      <= 1'b1;
          m_valid     <= 1'b1;
          pad_pending <= 1'b0;
          state       <= EMIT;
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
